// File: rtl/cxs_txflit_buf.sv
// CXS transmit flit buffer: software fills and commits flits into a circular
// slot queue; committed flits stream onto the CXS TX channel under credit control.
module cxs_txflit_buf #(
  parameter int AWIDTH     = 4,
  parameter int FLIT_WIDTH = 256,
  parameter int CNTL_WIDTH = 14,
  parameter int MAX_CRD    = 15
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     wr_en,
  input  logic [AWIDTH-1:0]        wr_addr,
  input  logic [FLIT_WIDTH/32-1:0] wr_word_en,
  input  logic [31:0]              wr_data,
  input  logic                     flit_commit,
  input  logic [CNTL_WIDTH-1:0]    flit_cntl,
  input  logic                     flush_req,
  output logic [AWIDTH-1:0]        tail_ptr,
  output logic                     tx_empty,
  output logic                     tx_full,
  output logic                     ovf_err,
  output logic                     crd_err,
  output logic                     flush_done,
  output logic                     cxs_tx_valid,
  output logic [FLIT_WIDTH-1:0]    cxs_tx_data,
  output logic [CNTL_WIDTH-1:0]    cxs_tx_cntl,
  input  logic                     cxs_tx_crdgnt,
  output logic                     cxs_tx_crdrtn
);

  localparam int NWORDS = FLIT_WIDTH / 32;
  localparam int DEPTH  = 1 << AWIDTH;
  localparam logic [AWIDTH:0] PTR_ONE  = {{AWIDTH{1'b0}}, 1'b1};
  localparam logic [AWIDTH:0] FULL_OCC = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [3:0]      CRD_MAX  = 4'(MAX_CRD);

  typedef enum logic [1:0] {
    ST_SEND,
    ST_RETURN,
    ST_DONE
  } state_t;

  logic [FLIT_WIDTH-1:0] data_ram [DEPTH];
  logic [CNTL_WIDTH-1:0] cntl_ram [DEPTH];

  logic [AWIDTH:0]   head;
  logic [AWIDTH:0]   tail;
  logic [AWIDTH:0]   occupancy;
  logic [3:0]        credits;
  logic              rd_pend;
  logic [AWIDTH-1:0] rd_addr;
  logic              commit_ok;
  logic              issue;
  logic              crd_ret;
  logic              consume;
  state_t            state;
  state_t            state_nxt;

  assign occupancy     = tail - head;
  assign tx_empty      = (occupancy == '0);
  assign tx_full       = (occupancy == FULL_OCC);
  assign tail_ptr      = tail[AWIDTH-1:0];
  assign commit_ok     = flit_commit && !tx_full;
  assign consume       = issue || crd_ret;
  assign cxs_tx_crdrtn = crd_ret;

  // Storage: contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned w = 0; w < NWORDS; w++) begin
        if (wr_word_en[w]) data_ram[wr_addr][w*32 +: 32] <= wr_data;
      end
    end
    if (commit_ok) cntl_ram[tail[AWIDTH-1:0]] <= flit_cntl;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head    <= '0;
      tail    <= '0;
      ovf_err <= 1'b0;
      rd_pend <= 1'b0;
      rd_addr <= '0;
    end else begin
      if (commit_ok) tail <= tail + PTR_ONE;
      if (flit_commit && tx_full) ovf_err <= 1'b1;
      if (issue) begin
        head    <= head + PTR_ONE;
        rd_addr <= head[AWIDTH-1:0];
      end
      rd_pend <= issue;
    end
  end

  // Grant and consume in the same cycle cancel; a lone grant at the limit saturates.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      credits <= '0;
      crd_err <= 1'b0;
    end else begin
      case ({cxs_tx_crdgnt, consume})
        2'b10: begin
          if (credits == CRD_MAX) crd_err <= 1'b1;
          else                    credits <= credits + 4'd1;
        end
        2'b01:   credits <= credits - 4'd1;
        default: credits <= credits;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cxs_tx_valid <= 1'b0;
      cxs_tx_data  <= '0;
      cxs_tx_cntl  <= '0;
    end else begin
      cxs_tx_valid <= rd_pend;
      if (rd_pend) begin
        cxs_tx_data <= data_ram[rd_addr];
        cxs_tx_cntl <= cntl_ram[rd_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_SEND;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    crd_ret    = 1'b0;
    flush_done = 1'b0;
    case (state)
      ST_SEND: begin
        issue = !tx_empty && (credits != '0) && !flush_req;
        // Wait for the read stage to drain so its flit is not lost.
        if (flush_req && !rd_pend) state_nxt = ST_RETURN;
      end
      ST_RETURN: begin
        crd_ret = (credits != '0);
        if ((credits == '0) && !cxs_tx_crdgnt) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        flush_done = 1'b1;
        if (!flush_req) state_nxt = ST_SEND;
      end
      default: state_nxt = ST_SEND;
    endcase
  end

endmodule

// File: tb/tb_cxs_txflit_buf.sv
// Self-checking bench for cxs_txflit_buf: random flits against a queue/credit
// model of what must appear on the CXS TX channel.
module tb_cxs_txflit_buf;
  localparam int AW = 4;
  localparam int FW = 256;
  localparam int CW = 14;
  localparam int MC = 15;
  localparam int NW = FW / 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [NW-1:0] wr_word_en;
  logic [31:0]   wr_data;
  logic          flit_commit;
  logic [CW-1:0] flit_cntl;
  logic          flush_req;
  logic [AW-1:0] tail_ptr;
  logic          tx_empty, tx_full, ovf_err, crd_err, flush_done;
  logic          cxs_tx_valid;
  logic [FW-1:0] cxs_tx_data;
  logic [CW-1:0] cxs_tx_cntl;
  logic          cxs_tx_crdgnt;
  logic          cxs_tx_crdrtn;

  always #5 clk = ~clk;

  cxs_txflit_buf #(.AWIDTH(AW), .FLIT_WIDTH(FW), .CNTL_WIDTH(CW), .MAX_CRD(MC)) dut (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_word_en(wr_word_en), .wr_data(wr_data), .flit_commit(flit_commit),
    .flit_cntl(flit_cntl), .flush_req(flush_req), .tail_ptr(tail_ptr),
    .tx_empty(tx_empty), .tx_full(tx_full), .ovf_err(ovf_err), .crd_err(crd_err),
    .flush_done(flush_done), .cxs_tx_valid(cxs_tx_valid), .cxs_tx_data(cxs_tx_data),
    .cxs_tx_cntl(cxs_tx_cntl), .cxs_tx_crdgnt(cxs_tx_crdgnt), .cxs_tx_crdrtn(cxs_tx_crdrtn)
  );

  typedef struct {
    logic [FW-1:0] data;
    logic [CW-1:0] cntl;
    int            cyc;
  } flit_t;

  flit_t obs_q[$];
  flit_t exp_q[$];
  int    cyc = 0;
  int    rtn_cnt = 0;
  int    pass_cnt = 0;
  int    chk_cnt = 0;

  // Reference model: slot images, queued-but-unsent count and credit pool.
  logic [FW-1:0] m_slot [16];
  int m_tail, m_pend, m_crd, m_sent;
  bit m_ovf, m_crderr;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cxs_tx_valid === 1'b1) begin
      flit_t f;
      f.data = cxs_tx_data;
      f.cntl = cxs_tx_cntl;
      f.cyc  = cyc;
      obs_q.push_back(f);
    end
    if (cxs_tx_crdrtn === 1'b1) rtn_cnt++;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void settle();
    int n;
    n = (m_pend < m_crd) ? m_pend : m_crd;
    m_pend -= n;
    m_crd  -= n;
    m_sent += n;
  endfunction

  function automatic void model_clear();
    m_tail = 0; m_pend = 0; m_crd = 0; m_sent = 0; m_ovf = 0; m_crderr = 0;
    obs_q.delete();
    exp_q.delete();
    rtn_cnt = 0;
  endfunction

  task automatic do_reset();
    resetn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_word_en = '0; wr_data = '0;
    flit_commit = 1'b0; flit_cntl = '0; flush_req = 1'b0; cxs_tx_crdgnt = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    model_clear();
  endtask

  task automatic wr(input int slot, input logic [NW-1:0] m, input logic [31:0] v);
    wr_en = 1'b1; wr_addr = AW'(slot); wr_word_en = m; wr_data = v;
    tick();
    wr_en = 1'b0; wr_word_en = '0;
    for (int w = 0; w < NW; w++) if (m[w]) m_slot[slot][w*32 +: 32] = v;
  endtask

  task automatic write_flit(input int slot);
    logic [NW-1:0] done, m;
    done = '0;
    repeat (2) begin
      m = NW'($urandom);
      wr(slot, m, $urandom);
      done |= m;
    end
    for (int w = 0; w < NW; w++) begin
      if (!done[w]) begin
        m = '0;
        m[w] = 1'b1;
        wr(slot, m, $urandom);
      end
    end
  endtask

  task automatic commit(input logic [CW-1:0] c);
    flit_t f;
    flit_cntl = c; flit_commit = 1'b1;
    tick();
    flit_commit = 1'b0;
    if (m_pend >= 16) m_ovf = 1'b1;
    else begin
      f.data = m_slot[m_tail]; f.cntl = c; f.cyc = 0;
      exp_q.push_back(f);
      m_tail = (m_tail + 1) % 16;
      m_pend++;
      settle();
    end
  endtask

  task automatic commit_rand();
    write_flit(m_tail);
    commit(CW'($urandom));
  endtask

  task automatic grant(input int n);
    repeat (n) begin
      cxs_tx_crdgnt = 1'b1;
      tick();
      if (m_crd == MC) m_crderr = 1'b1;
      else m_crd++;
      settle();
    end
    cxs_tx_crdgnt = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    chk_cnt++;
    if ({cxs_tx_valid, cxs_tx_crdrtn, flush_done, ovf_err, crd_err, tx_full, tx_empty} !== 7'b0000001)
      $display("FAIL reset_flags: got %b want 0000001",
               {cxs_tx_valid, cxs_tx_crdrtn, flush_done, ovf_err, crd_err, tx_full, tx_empty});
    else pass_cnt++;
    chk_cnt++;
    if (tail_ptr !== '0) $display("FAIL reset_tail: got %0d want 0", tail_ptr); else pass_cnt++;
    chk_cnt++;
    if (cxs_tx_data !== '0) $display("FAIL reset_data: got %h want 0", cxs_tx_data); else pass_cnt++;
    chk_cnt++;
    if (cxs_tx_cntl !== '0) $display("FAIL reset_cntl: got %h want 0", cxs_tx_cntl); else pass_cnt++;
  endtask

  task automatic test_single_flit();
    logic [FW-1:0] val;
    logic [3:0]    vseq;
    logic [NW-1:0] m;
    do_reset();
    grant(1);
    for (int n = 0; n < NW; n++) val[n*32 +: 32] = 32'h1000 + 32'(n);
    for (int n = 0; n < NW; n++) begin
      m = '0; m[n] = 1'b1;
      wr(0, m, val[n*32 +: 32]);
    end
    commit(14'h2A5);
    vseq[3] = cxs_tx_valid;
    tick(); vseq[2] = cxs_tx_valid;
    tick(); vseq[1] = cxs_tx_valid;
    chk_cnt++;
    if (cxs_tx_data !== val || cxs_tx_cntl !== 14'h2A5)
      $display("FAIL single_flit: got cntl %h data %h want cntl 2a5 data %h", cxs_tx_cntl, cxs_tx_data, val);
    else pass_cnt++;
    tick(); vseq[0] = cxs_tx_valid;
    chk_cnt++;
    if (vseq !== 4'b0010) $display("FAIL single_latency: got %b want 0010", vseq); else pass_cnt++;
    chk_cnt++;
    if (cxs_tx_data !== val || cxs_tx_cntl !== 14'h2A5)
      $display("FAIL single_hold: got cntl %h data %h want cntl 2a5 data %h", cxs_tx_cntl, cxs_tx_data, val);
    else pass_cnt++;
    chk_cnt++;
    if (tx_empty !== 1'b1) $display("FAIL single_empty: got %b want 1", tx_empty); else pass_cnt++;
    commit_rand();
    repeat (20) tick();
    chk_cnt++;
    if (obs_q.size() != m_sent) $display("FAIL single_nocredit: got %0d flits want %0d", obs_q.size(), m_sent);
    else pass_cnt++;
    grant(1);
    repeat (10) tick();
    chk_cnt++;
    if (obs_q.size() != m_sent) $display("FAIL single_count: got %0d flits want %0d", obs_q.size(), m_sent);
    else pass_cnt++;
    for (int i = 0; i < m_sent && i < obs_q.size(); i++) begin
      chk_cnt++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].cntl !== exp_q[i].cntl)
        $display("FAIL single_flit%0d: got cntl %h data %h want cntl %h data %h", i,
                 obs_q[i].cntl, obs_q[i].data, exp_q[i].cntl, exp_q[i].data);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    repeat (15) commit_rand();
    grant(15);
    repeat (10) tick();
    chk_cnt++;
    if (obs_q.size() != m_sent) $display("FAIL b2b_count15: got %0d want %0d", obs_q.size(), m_sent);
    else pass_cnt++;
    for (int i = 1; i < obs_q.size(); i++) begin
      chk_cnt++;
      if (obs_q[i].cyc != obs_q[0].cyc + i)
        $display("FAIL b2b_gap%0d: got cycle %0d want %0d", i, obs_q[i].cyc, obs_q[0].cyc + i);
      else pass_cnt++;
    end
    repeat (5) commit_rand();
    repeat (20) tick();
    chk_cnt++;
    if (obs_q.size() != m_sent || tx_empty !== 1'b0)
      $display("FAIL b2b_stall: got %0d flits empty %b want %0d flits empty 0", obs_q.size(), tx_empty, m_sent);
    else pass_cnt++;
    grant(5);
    repeat (10) tick();
    chk_cnt++;
    if (obs_q.size() != m_sent) $display("FAIL b2b_count20: got %0d want %0d", obs_q.size(), m_sent);
    else pass_cnt++;
    for (int i = 0; i < m_sent && i < obs_q.size(); i++) begin
      chk_cnt++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].cntl !== exp_q[i].cntl)
        $display("FAIL b2b_flit%0d: got cntl %h data %h want cntl %h data %h", i,
                 obs_q[i].cntl, obs_q[i].data, exp_q[i].cntl, exp_q[i].data);
      else pass_cnt++;
    end
    chk_cnt++;
    if (tx_empty !== 1'b1 || tail_ptr !== AW'(m_tail))
      $display("FAIL b2b_ptr: got empty %b tail %0d want empty 1 tail %0d", tx_empty, tail_ptr, m_tail);
    else pass_cnt++;
  endtask

  task automatic test_full_ovf();
    do_reset();
    repeat (16) commit_rand();
    chk_cnt++;
    if ({tx_full, ovf_err, tx_empty} !== {1'b1, m_ovf, 1'b0} || tail_ptr !== AW'(m_tail))
      $display("FAIL full_16: got full %b ovf %b empty %b tail %0d want 1 %b 0 %0d",
               tx_full, ovf_err, tx_empty, tail_ptr, m_ovf, m_tail);
    else pass_cnt++;
    commit(CW'($urandom));
    chk_cnt++;
    if ({tx_full, ovf_err} !== {1'b1, m_ovf} || tail_ptr !== AW'(m_tail))
      $display("FAIL full_ovf: got full %b ovf %b tail %0d want 1 %b %0d", tx_full, ovf_err, tail_ptr, m_ovf, m_tail);
    else pass_cnt++;
    grant(15);
    repeat (25) tick();
    grant(1);
    repeat (10) tick();
    chk_cnt++;
    if (obs_q.size() != m_sent || tx_empty !== 1'b1)
      $display("FAIL full_drain: got %0d flits empty %b want %0d empty 1", obs_q.size(), tx_empty, m_sent);
    else pass_cnt++;
    for (int i = 0; i < m_sent && i < obs_q.size(); i++) begin
      chk_cnt++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].cntl !== exp_q[i].cntl)
        $display("FAIL full_flit%0d: got cntl %h data %h want cntl %h data %h", i,
                 obs_q[i].cntl, obs_q[i].data, exp_q[i].cntl, exp_q[i].data);
      else pass_cnt++;
    end
  endtask

  task automatic test_crd_sat();
    flit_t f;
    do_reset();
    grant(15);
    chk_cnt++;
    if (crd_err !== m_crderr) $display("FAIL sat_pre: got crd_err %b want %b", crd_err, m_crderr); else pass_cnt++;
    grant(1);
    chk_cnt++;
    if (crd_err !== m_crderr) $display("FAIL sat_err: got crd_err %b want %b", crd_err, m_crderr); else pass_cnt++;
    repeat (16) commit_rand();
    repeat (10) tick();
    chk_cnt++;
    if (obs_q.size() != m_sent || tx_empty !== 1'b0)
      $display("FAIL sat_count: got %0d flits empty %b want %0d empty 0", obs_q.size(), tx_empty, m_sent);
    else pass_cnt++;
    // Grant arrives in the very cycle the committed flit issues.
    do_reset();
    grant(3);
    write_flit(0);
    flit_cntl = CW'($urandom); flit_commit = 1'b1;
    tick();
    flit_commit = 1'b0; cxs_tx_crdgnt = 1'b1;
    f.data = m_slot[0]; f.cntl = flit_cntl; f.cyc = 0;
    exp_q.push_back(f);
    m_tail = 1; m_pend = 1;
    settle();
    tick();
    cxs_tx_crdgnt = 1'b0;
    m_crd++;
    repeat (4) commit_rand();
    repeat (10) tick();
    chk_cnt++;
    if (obs_q.size() != m_sent || crd_err !== 1'b0)
      $display("FAIL simul_count: got %0d flits crd_err %b want %0d crd_err 0", obs_q.size(), crd_err, m_sent);
    else pass_cnt++;
    for (int i = 0; i < m_sent && i < obs_q.size(); i++) begin
      chk_cnt++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].cntl !== exp_q[i].cntl)
        $display("FAIL simul_flit%0d: got cntl %h data %h want cntl %h data %h", i,
                 obs_q[i].cntl, obs_q[i].data, exp_q[i].cntl, exp_q[i].data);
      else pass_cnt++;
    end
  endtask

  task automatic test_flush();
    int exp_rtn;
    do_reset();
    grant(3);
    flush_req = 1'b1;
    exp_rtn = m_crd; m_crd = 0;
    tick();
    tick();
    grant(1);
    exp_rtn += m_crd; m_crd = 0;
    commit_rand();
    for (int i = 0; i < 40 && flush_done !== 1'b1; i++) tick();
    chk_cnt++;
    if (flush_done !== 1'b1) $display("FAIL flush_done: got %b want 1", flush_done); else pass_cnt++;
    chk_cnt++;
    if (rtn_cnt != exp_rtn) $display("FAIL flush_rtn: got %0d returns want %0d", rtn_cnt, exp_rtn); else pass_cnt++;
    grant(1);
    repeat (5) tick();
    chk_cnt++;
    if (obs_q.size() != 0 || rtn_cnt != exp_rtn || flush_done !== 1'b1)
      $display("FAIL flush_hold: got %0d flits %0d returns done %b want 0 %0d 1", obs_q.size(), rtn_cnt, exp_rtn, flush_done);
    else pass_cnt++;
    flush_req = 1'b0;
    tick();
    chk_cnt++;
    if (flush_done !== 1'b0) $display("FAIL flush_exit: got %b want 0", flush_done); else pass_cnt++;
    repeat (10) tick();
    chk_cnt++;
    if (obs_q.size() != m_sent || rtn_cnt != exp_rtn)
      $display("FAIL flush_resume: got %0d flits %0d returns want %0d %0d", obs_q.size(), rtn_cnt, m_sent, exp_rtn);
    else pass_cnt++;
    for (int i = 0; i < m_sent && i < obs_q.size(); i++) begin
      chk_cnt++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].cntl !== exp_q[i].cntl)
        $display("FAIL flush_flit%0d: got cntl %h data %h want cntl %h data %h", i,
                 obs_q[i].cntl, obs_q[i].data, exp_q[i].cntl, exp_q[i].data);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (16) commit_rand();
    commit(CW'($urandom));
    chk_cnt++;
    if (ovf_err !== m_ovf) $display("FAIL mid_ovf: got %b want %b", ovf_err, m_ovf); else pass_cnt++;
    cxs_tx_crdgnt = 1'b1;
    repeat (6) tick();
    chk_cnt++;
    if (cxs_tx_valid !== 1'b1) $display("FAIL mid_stream: got valid %b want 1", cxs_tx_valid); else pass_cnt++;
    resetn = 1'b0;
    tick();
    chk_cnt++;
    if ({cxs_tx_valid, cxs_tx_crdrtn, ovf_err, crd_err, tx_full, tx_empty} !== 6'b000001 || tail_ptr !== '0)
      $display("FAIL mid_reset: got flags %b tail %0d want 000001 tail 0",
               {cxs_tx_valid, cxs_tx_crdrtn, ovf_err, crd_err, tx_full, tx_empty}, tail_ptr);
    else pass_cnt++;
    chk_cnt++;
    if (cxs_tx_data !== '0 || cxs_tx_cntl !== '0)
      $display("FAIL mid_outs: got cntl %h data %h want 0", cxs_tx_cntl, cxs_tx_data);
    else pass_cnt++;
    resetn = 1'b1;
    cxs_tx_crdgnt = 1'b0;
    model_clear();
    commit_rand();
    repeat (15) tick();
    chk_cnt++;
    if (obs_q.size() != m_sent) $display("FAIL mid_credits: got %0d flits want %0d", obs_q.size(), m_sent);
    else pass_cnt++;
    grant(1);
    repeat (10) tick();
    chk_cnt++;
    if (obs_q.size() != m_sent) $display("FAIL mid_after: got %0d flits want %0d", obs_q.size(), m_sent);
    else pass_cnt++;
    for (int i = 0; i < m_sent && i < obs_q.size(); i++) begin
      chk_cnt++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].cntl !== exp_q[i].cntl)
        $display("FAIL mid_flit%0d: got cntl %h data %h want cntl %h data %h", i,
                 obs_q[i].cntl, obs_q[i].data, exp_q[i].cntl, exp_q[i].data);
      else pass_cnt++;
    end
  endtask

  initial begin
    resetn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_word_en = '0; wr_data = '0;
    flit_commit = 1'b0; flit_cntl = '0; flush_req = 1'b0; cxs_tx_crdgnt = 1'b0;
    test_reset();
    test_single_flit();
    test_back_to_back();
    test_full_ovf();
    test_crd_sat();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
